adc_sample_store: RTL
=====================

Name: adc_sample_store

Overview:
- Downstream of the AD79X8 serial interface master.
- Consumes each completed 16-bit DOUT conversion frame and checks its leading-zero bit.
- Decodes the 3-bit channel address and stores the DIGITS-wide result in a per-channel register file.
- Keeps fresh/overrun/alarm status per channel and presents a registered single-channel read port plus an interrupt to the host-side logic.

Parameters:
DIGITS, 8, ADC resolution: 8 = AD7908, 10 = AD7918, 12 = AD7928; legal values 8, 10, 12 only
CHANNELS, 8, number of stored channels; fixed at 8 (3-bit address field)
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
frame_in  in  16  raw DOUT frame, MSB first-shifted bit at [15]
frame_valid  in  1  one-cycle strobe: frame_in complete
rd_en  in  1  read request
rd_ch  in  3  channel to read
rd_data  out  DIGITS  stored sample of rd_ch
rd_valid  out  1  one-cycle strobe, rd_data valid
rd_fresh  out  1  channel held an unread sample at read time
rd_overrun  out  1  sticky overrun flag of rd_ch at read time
hi_limit  in  DIGITS  upper alarm threshold (unsigned)
lo_limit  in  DIGITS  lower alarm threshold (unsigned)
alarm_mask  in  8  per-channel alarm enable
status_clr  in  1  clears all overrun and alarm flags
fresh  out  8  per-channel unread-sample flags
alarm  out  8  per-channel sticky alarm flags
irq  out  1  registered OR of alarm
frame_err  out  1  one-cycle pulse: rejected frame
frame_cnt  out  CNT_W  count of accepted frames, wraps

Behaviour:
- Frame fields (AD79X8 DOUT):
  - bit15 must be 0.
  - [14:12] channel address.
  - [11:12-DIGITS] sample, MSB-aligned.
  - Bits below the sample are ignored.
- Reset (reset==0 at clk edge): all storage, fresh, overrun, alarm, irq, rd_data, rd_valid, rd_fresh, rd_overrun, frame_err, frame_cnt = 0. Reset overrides every other input the same cycle; any frame or read in that cycle is dropped.
- Accept, frame_valid && frame_in[15]==0, next edge:
  - data[ch] <= sample; fresh[ch] <= 1; frame_cnt++ (wraps 2^CNT_W-1 -> 0).
  - If fresh[ch] was already 1 and no read of ch completes this cycle: overrun[ch] <= 1.
  - If alarm_mask[ch] && (sample > hi_limit || sample < lo_limit): alarm[ch] <= 1. Comparison is strict. hi_limit < lo_limit means every sample alarms; no special handling.
- Reject, frame_valid && frame_in[15]==1: frame_err=1 for one cycle; no storage, flag or counter change.
- Read, rd_en: latency 1 cycle.
  - rd_data, rd_fresh and rd_overrun reflect pre-edge values of channel rd_ch.
  - rd_valid=1 that cycle, else rd_valid=0. rd_data holds its last value when rd_valid=0.
  - fresh[rd_ch] <= 0.
- Same-channel accept and read in one cycle:
  - Read returns the old data and old fresh.
  - Storage takes the new sample; fresh stays 1.
  - Overrun is not set.
- Different channels in the same cycle: both proceed independently.
- status_clr clears overrun[] and alarm[] at the edge. If it coincides with a setting event on the same channel, the set wins.
- irq is registered from post-update alarm: 1 cycle after the alarm flag rises. irq drops 1 cycle after status_clr.
- No back-pressure: a frame is accepted every cycle frame_valid is high. Back-to-back frames are legal.

Decomposition:
- Package adc79x8_pkg:
  - Constants FRAME_W=16, ZERO_BIT=15, ADD_HI=14, ADD_LO=12, DATA_MSB=11.
  - Function giving the sample LSB from DIGITS (12-DIGITS).
  - Channel-index typedef (3 bits).
- Sub-module adc_ch_regfile holds:
  - 8 x DIGITS storage.
  - fresh/overrun flags.
  - One write port and one registered read port, including the same-cycle collision rule.
- Top level keeps:
  - Frame decode/reject.
  - Alarm compare.
  - irq.
  - frame counter.

Test Plan:
1. Hold reset=0 for 3 cycles while asserting frame_valid with frame 0x2A50 -> every output reads 0; frame_cnt=0.
2. DIGITS=8, frame 0x5AB0 (ch5, sample 0xAB), then rd_en with rd_ch=5 -> next cycle rd_data=0xAB, rd_valid=1, rd_fresh=1, rd_overrun=0, fresh[5]=0, frame_cnt=1.
3. Two frames to ch2 (0x2110, then 0x2220) with no read between, then read ch2 -> rd_data=0x22, rd_overrun=1. Then status_clr -> the next read of ch2 gives rd_overrun=0.
4. Frame 0x8FF0 (bit15 set) -> frame_err pulse of 1 cycle; fresh, data and frame_cnt unchanged.
5. Read of ch3 in the same cycle as frame 0x3440 to ch3, ch3 previously holding 0x12 -> rd_data=0x12; fresh[3] stays 1; overrun[3]=0; a following read returns 0x44.
6. hi_limit=0x80, lo_limit=0x10, alarm_mask=0x01:
   - Frame 0x0810 (ch0, sample 0x81) -> alarm[0]=1, and irq=1 one cycle later.
   - Frame 0x1810 (ch1, same sample) -> no alarm.
   - status_clr -> alarm cleared and irq drops next cycle.

Source files
------------

// File: rtl/adc79x8_pkg.sv
// Shared constants and types for the AD79X8 sample store.
// Frame field positions follow the converter's DOUT layout.
package adc79x8_pkg;

  localparam int FRAME_W  = 16;
  localparam int ZERO_BIT = 15;
  localparam int ADD_HI   = 14;
  localparam int ADD_LO   = 12;
  localparam int DATA_MSB = 11;

  typedef logic [2:0] ch_t;

  function automatic int sample_lsb(input int digits);
    return 12 - digits;
  endfunction

endpackage

// File: rtl/adc_ch_regfile.sv
// Per-channel sample storage with fresh/overrun flags.
// One write port, one registered read port.
module adc_ch_regfile
  import adc79x8_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int CHANNELS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [2:0]          wr_ch,
  input  logic [DIGITS-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [2:0]          rd_ch,
  input  logic                ovr_clr,
  output logic [DIGITS-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_fresh,
  output logic                rd_overrun,
  output logic [CHANNELS-1:0] fresh
);

  logic [DIGITS-1:0]   mem [CHANNELS];
  logic [CHANNELS-1:0] overrun;
  logic [CHANNELS-1:0] fresh_nxt;
  logic [CHANNELS-1:0] ovr_nxt;
  logic                same_rd;

  assign same_rd = rd_en && (rd_ch == wr_ch);

  // A write always leaves the channel fresh, even if read this cycle
  always_comb begin
    fresh_nxt = fresh;
    ovr_nxt   = ovr_clr ? '0 : overrun;
    if (rd_en) fresh_nxt[rd_ch] = 1'b0;
    if (wr_en) begin
      fresh_nxt[wr_ch] = 1'b1;
      if (fresh[wr_ch] && !same_rd)
        ovr_nxt[wr_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++)
        mem[i] <= '0;
      fresh      <= '0;
      overrun    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_fresh   <= 1'b0;
      rd_overrun <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data    <= mem[rd_ch];
        rd_fresh   <= fresh[rd_ch];
        rd_overrun <= overrun[rd_ch];
      end
      if (wr_en) mem[wr_ch] <= wr_data;
      fresh   <= fresh_nxt;
      overrun <= ovr_nxt;
    end
  end

endmodule

// File: rtl/adc_sample_store.sv
// AD79X8 frame decoder feeding a per-channel sample store,
// with limit alarms, interrupt and accepted-frame counter.
module adc_sample_store
  import adc79x8_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         frame_in,
  input  logic                frame_valid,
  input  logic                rd_en,
  input  logic [2:0]          rd_ch,
  output logic [DIGITS-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_fresh,
  output logic                rd_overrun,
  input  logic [DIGITS-1:0]   hi_limit,
  input  logic [DIGITS-1:0]   lo_limit,
  input  logic [7:0]          alarm_mask,
  input  logic                status_clr,
  output logic [CHANNELS-1:0] fresh,
  output logic [CHANNELS-1:0] alarm,
  output logic                irq,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam int LSB = sample_lsb(DIGITS);

  logic                accept;
  logic                reject;
  ch_t                 ch;
  logic [DATA_MSB:0]   field;
  logic [DIGITS-1:0]   sample;
  logic                hit;
  logic [CHANNELS-1:0] alarm_nxt;

  assign accept = frame_valid && !frame_in[ZERO_BIT];
  assign reject = frame_valid &&  frame_in[ZERO_BIT];
  assign ch     = frame_in[ADD_HI:ADD_LO];
  assign field  = frame_in[DATA_MSB:0];
  // Low bits below the sample shift out and are discarded
  assign sample = DIGITS'(field >> LSB);
  assign hit    = accept && alarm_mask[ch] &&
                  (sample > hi_limit || sample < lo_limit);

  always_comb begin
    alarm_nxt = status_clr ? '0 : alarm;
    if (hit) alarm_nxt[ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alarm     <= '0;
      irq       <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      alarm     <= alarm_nxt;
      irq       <= |alarm;
      frame_err <= reject;
      if (accept) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  adc_ch_regfile #(
    .DIGITS   (DIGITS),
    .CHANNELS (CHANNELS)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (accept),
    .wr_ch      (ch),
    .wr_data    (sample),
    .rd_en      (rd_en),
    .rd_ch      (rd_ch),
    .ovr_clr    (status_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_fresh   (rd_fresh),
    .rd_overrun (rd_overrun),
    .fresh      (fresh)
  );

endmodule
